// File: rtl/cafe_vendor_ctrl.sv
// rtl/cafe_vendor_ctrl.sv - coffee vending controller: coin credit, drink selection, valve sequencing, change
// Credit saturates at MAX_CREDIT; each valve step lasts effective_seconds * TICK_DIV cycles.
module cafe_vendor_ctrl #(
  parameter int N_DRINKS   = 4,
  parameter int CREDIT_W   = 8,
  parameter int MAX_CREDIT = 11,
  parameter logic [N_DRINKS*CREDIT_W-1:0] PRICES = {8'd7, 8'd5, 8'd4, 8'd3},
  parameter logic [N_DRINKS*5*4-1:0]      RECIPE = 80'h12201111111021110012,
  parameter int TICK_DIV   = 50_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                moneda100,
  input  logic                moneda500,
  input  logic                sel_valid,
  input  logic [3:0]          sel_idx,
  input  logic [1:0]          azucar_extra,
  input  logic                cancelar,
  output logic [4:0]          valvulas,
  output logic [CREDIT_W-1:0] credito,
  output logic [CREDIT_W-1:0] vuelto,
  output logic                vuelto_valid,
  output logic                moneda_rechazo,
  output logic                sel_denegada,
  output logic                ocupado,
  output logic                bebida_lista
);

  localparam int CNT_W = $clog2(18 * TICK_DIV + 1);
  localparam int SW    = CREDIT_W + 3;

  typedef enum logic [1:0] {S_IDLE, S_DISPENSE, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CREDIT_W-1:0] vuelto_q, vuelto_d;
  logic                vv_q, vv_d;
  logic                rech_q, rech_d;
  logic                den_q, den_d;
  logic                lista_q, lista_d;
  logic [3:0]          drink_q, drink_d;
  logic [1:0]          azu_q, azu_d;
  logic [2:0]          step_q, step_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  function automatic logic [3:0] eff_time(input logic [3:0] d, input logic [1:0] a,
                                          input logic [2:0] i);
    logic [3:0] base;
    logic [4:0] s;
    if (int'(d) < N_DRINKS && i < 3'd5) base = RECIPE[(int'(d) * 5 + int'(i)) * 4 +: 4];
    else                                base = 4'd0;
    s = {1'b0, base} + {3'b000, a};
    if (i == 3'd4) eff_time = (s > 5'd15) ? 4'd15 : s[3:0];
    else           eff_time = base;
  endfunction

  // Lowest ingredient index >= from with a nonzero time; 5 means none left.
  function automatic logic [2:0] next_step(input logic [3:0] d, input logic [1:0] a,
                                           input logic [2:0] from);
    next_step = 3'd5;
    for (int i = 4; i >= 0; i--) begin
      if (i >= int'(from) && eff_time(d, a, 3'(i)) != 4'd0) next_step = 3'(i);
    end
  endfunction

  function automatic logic [CREDIT_W-1:0] price_of(input logic [3:0] d);
    if (int'(d) < N_DRINKS) price_of = PRICES[int'(d) * CREDIT_W +: CREDIT_W];
    else                    price_of = '0;
  endfunction

  logic [CREDIT_W-1:0] sel_price;
  logic [2:0]          first_step, nxt_step;
  logic [3:0]          cur_eff;
  logic [CNT_W-1:0]    step_len;
  logic [SW-1:0]       sum_all, sum_100;
  logic                coin_any, sel_ok, enter_done;

  always_comb begin
    sel_price  = price_of(sel_idx);
    sel_ok     = (int'(sel_idx) < N_DRINKS) && (credit_q >= sel_price);
    first_step = next_step(sel_idx, azucar_extra, 3'd0);
    cur_eff    = eff_time(drink_q, azu_q, step_q);
    step_len   = CNT_W'(cur_eff) * CNT_W'(TICK_DIV);
    sum_100    = {3'b000, credit_q} + SW'(moneda100);
    sum_all    = sum_100 + (moneda500 ? SW'(5) : SW'(0));
    coin_any   = moneda100 | moneda500;
  end

  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    vuelto_d   = '0;
    vv_d       = 1'b0;
    rech_d     = 1'b0;
    den_d      = 1'b0;
    lista_d    = 1'b0;
    drink_d    = drink_q;
    azu_d      = azu_q;
    step_d     = step_q;
    cnt_d      = cnt_q;
    nxt_step   = 3'd5;
    enter_done = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cancelar) begin
          rech_d = coin_any;
          if (credit_q != '0) begin
            vuelto_d = credit_q;
            vv_d     = 1'b1;
            credit_d = '0;
          end
        end else if (sel_valid && sel_ok) begin
          rech_d   = coin_any;
          credit_d = credit_q - sel_price;
          drink_d  = sel_idx;
          azu_d    = azucar_extra;
          cnt_d    = '0;
          if (first_step == 3'd5) begin
            state_d    = S_DONE;
            enter_done = 1'b1;
          end else begin
            step_d  = first_step;
            state_d = S_DISPENSE;
          end
        end else begin
          den_d = sel_valid;
          if (sum_all <= SW'(MAX_CREDIT)) begin
            credit_d = sum_all[CREDIT_W-1:0];
          end else if (moneda100 && sum_100 <= SW'(MAX_CREDIT)) begin
            credit_d = sum_100[CREDIT_W-1:0];
            rech_d   = 1'b1;
          end else begin
            rech_d = coin_any;
          end
        end
      end
      S_DISPENSE: begin
        rech_d = coin_any;
        if (cnt_q == step_len - CNT_W'(1)) begin
          nxt_step = next_step(drink_q, azu_q, step_q + 3'd1);
          cnt_d    = '0;
          if (nxt_step == 3'd5) begin
            state_d    = S_DONE;
            enter_done = 1'b1;
          end else begin
            step_d = nxt_step;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        rech_d  = coin_any;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Change and completion strobes are raised on entry so they sit in the DONE cycle.
    if (enter_done) begin
      lista_d = 1'b1;
      if (credit_d != '0) begin
        vuelto_d = credit_d;
        vv_d     = 1'b1;
        credit_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      credit_q <= '0;
      vuelto_q <= '0;
      vv_q     <= 1'b0;
      rech_q   <= 1'b0;
      den_q    <= 1'b0;
      lista_q  <= 1'b0;
      drink_q  <= '0;
      azu_q    <= '0;
      step_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      vuelto_q <= vuelto_d;
      vv_q     <= vv_d;
      rech_q   <= rech_d;
      den_q    <= den_d;
      lista_q  <= lista_d;
      drink_q  <= drink_d;
      azu_q    <= azu_d;
      step_q   <= step_d;
      cnt_q    <= cnt_d;
    end
  end

  assign valvulas       = (state_q == S_DISPENSE) ? (5'b00001 << step_q) : 5'b00000;
  assign credito        = credit_q;
  assign vuelto         = vuelto_q;
  assign vuelto_valid   = vv_q;
  assign moneda_rechazo = rech_q;
  assign sel_denegada   = den_q;
  assign ocupado        = (state_q != S_IDLE);
  assign bebida_lista   = lista_q;

endmodule

// File: tb/tb_cafe_vendor_ctrl.sv
// tb/tb_cafe_vendor_ctrl.sv - directed self-checking bench for cafe_vendor_ctrl
module tb_cafe_vendor_ctrl;

  logic       clk;
  logic       rst;
  logic       moneda100, moneda500, sel_valid, cancelar;
  logic [3:0] sel_idx;
  logic [1:0] azucar_extra;
  logic [4:0] valvulas;
  logic [7:0] credito, vuelto;
  logic       vuelto_valid, moneda_rechazo, sel_denegada, ocupado, bebida_lista;

  int n_assert = 0;
  int n_fail   = 0;

  cafe_vendor_ctrl #(.TICK_DIV(4)) dut (
    .clk(clk), .rst(rst),
    .moneda100(moneda100), .moneda500(moneda500),
    .sel_valid(sel_valid), .sel_idx(sel_idx), .azucar_extra(azucar_extra),
    .cancelar(cancelar),
    .valvulas(valvulas), .credito(credito), .vuelto(vuelto),
    .vuelto_valid(vuelto_valid), .moneda_rechazo(moneda_rechazo),
    .sel_denegada(sel_denegada), .ocupado(ocupado), .bebida_lista(bebida_lista)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    moneda100 = 1'b0;
    moneda500 = 1'b0;
    sel_valid = 1'b0;
    cancelar  = 1'b0;
  endtask

  initial begin
    int n;
    logic [4:0] exp_v;
    rst = 1'b1; moneda100 = 0; moneda500 = 0; sel_valid = 0; cancelar = 0;
    sel_idx = 4'd0; azucar_extra = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_credito", credito, 0);
    chk("rst_vuelto", vuelto, 0);
    chk("rst_valvulas", valvulas, 0);
    chk("rst_ocupado", ocupado, 0);
    chk("rst_vv", vuelto_valid, 0);
    chk("rst_lista", bebida_lista, 0);
    chk("rst_rech", moneda_rechazo, 0);
    chk("rst_den", sel_denegada, 0);
    rst = 1'b0;
    tick();

    moneda100 = 1; tick(); chk("coin_100", credito, 1);
    moneda500 = 1; tick(); chk("coin_500a", credito, 6);
    moneda500 = 1; tick(); chk("coin_500b", credito, 11);
    moneda100 = 1; tick();
    chk("ceil_rech", moneda_rechazo, 1);
    chk("ceil_credito", credito, 11);
    tick(); chk("ceil_rech_one", moneda_rechazo, 0);

    cancelar = 1; tick();
    chk("cancel11_vv", vuelto_valid, 1);
    chk("cancel11_vuelto", vuelto, 11);
    chk("cancel11_credito", credito, 0);
    tick(); chk("cancel11_vv_one", vuelto_valid, 0);

    moneda500 = 1; tick();
    moneda500 = 1; tick(); chk("credit10", credito, 10);
    moneda100 = 1; moneda500 = 1; tick();
    chk("both_credito", credito, 11);
    chk("both_rech", moneda_rechazo, 1);
    tick(); chk("both_rech_one", moneda_rechazo, 0);
    cancelar = 1; tick();

    // Expreso with 2 s extra sugar: agua 8, cafe 4, azucar 12 cycles.
    moneda500 = 1; tick(); chk("exp_credit5", credito, 5);
    sel_valid = 1; sel_idx = 4'd0; azucar_extra = 2'd2; tick();
    chk("exp_ocupado", ocupado, 1);
    chk("exp_credito", credito, 2);
    for (int i = 0; i < 24; i++) begin
      exp_v = (i < 8) ? 5'b00001 : (i < 12) ? 5'b00010 : 5'b10000;
      chk($sformatf("exp_valve_%0d", i), valvulas, exp_v);
      if (i == 3) begin
        chk("disp_rech", moneda_rechazo, 1);
        chk("disp_credito", credito, 2);
        chk("disp_no_vv", vuelto_valid, 0);
      end
      if (i == 2) begin
        moneda100 = 1; moneda500 = 1; cancelar = 1; sel_valid = 1; sel_idx = 4'd1;
      end
      tick();
    end
    chk("exp_lista", bebida_lista, 1);
    chk("exp_vv", vuelto_valid, 1);
    chk("exp_vuelto", vuelto, 2);
    chk("exp_credito0", credito, 0);
    chk("exp_valv_off", valvulas, 0);
    tick();
    chk("exp_lista_one", bebida_lista, 0);
    chk("exp_idle", ocupado, 0);

    repeat (4) begin moneda100 = 1; tick(); end
    chk("den_credit4", credito, 4);
    sel_valid = 1; sel_idx = 4'd3; tick();
    chk("den_price", sel_denegada, 1);
    chk("den_price_credito", credito, 4);
    chk("den_price_idle", ocupado, 0);
    sel_valid = 1; sel_idx = 4'd9; tick();
    chk("den_idx", sel_denegada, 1);
    tick(); chk("den_one", sel_denegada, 0);

    moneda100 = 1; tick();
    moneda100 = 1; tick(); chk("cancel_credit6", credito, 6);
    cancelar = 1; tick();
    chk("cancel6_vv", vuelto_valid, 1);
    chk("cancel6_vuelto", vuelto, 6);
    chk("cancel6_credito", credito, 0);

    // Reset in the cafe step of an expreso.
    moneda500 = 1; tick();
    sel_valid = 1; sel_idx = 4'd0; azucar_extra = 2'd0; tick();
    repeat (8) tick();
    chk("mid_cafe", valvulas, 5'b00010);
    rst = 1'b1;
    #1;
    chk("mid_rst_valv", valvulas, 0);
    chk("mid_rst_ocupado", ocupado, 0);
    chk("mid_rst_credito", credito, 0);
    chk("mid_rst_vv", vuelto_valid, 0);
    #2;
    rst = 1'b0;
    tick();

    // Cafe-leche after reset: 5 s total, 20 cycles, change 1.
    moneda500 = 1; tick();
    sel_valid = 1; sel_idx = 4'd1; tick();
    chk("post_credito", credito, 1);
    chk("post_agua", valvulas, 5'b00001);
    n = 0;
    while (bebida_lista !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("post_cycles", n, 20);
    chk("post_vv", vuelto_valid, 1);
    chk("post_vuelto", vuelto, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
